i2c_arbiter: RTL

//  Round-robin arbiter sharing the single PMIC i2c_master between NUM_CLIENTS register-access clients
//  (power control, VCOM adjust, host debug access). Each client issues one-byte register read/write

---
 rtl/i2c_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one PMIC i2c_master between several register-access clients,
// with a busy watchdog and master reset on NACK or timeout.
module i2c_arbiter #(
   parameter int NUM_CLIENTS  = 2,
   parameter int TIMEOUT_BITS = 20,
   parameter int RST_CYCLES   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CLIENTS-1:0]   cl_req,
   input  logic [NUM_CLIENTS-1:0]   cl_rw,
   input  logic [8*NUM_CLIENTS-1:0] cl_subaddr,
   input  logic [8*NUM_CLIENTS-1:0] cl_wrdata,
   output logic [NUM_CLIENTS-1:0]   cl_ack,
   output logic                     cl_err,
   output logic [7:0]               cl_rddata,
   output logic                     m_rw,
   output logic [7:0]               m_subaddr,
   output logic [7:0]               m_wrdata,
   output logic                     m_req,
   output logic                     m_rst,
   input  logic                     m_busy,
   input  logic                     m_nack,
   input  logic [7:0]               m_rddata,
   output logic [2:0]               grant_id,
   output logic [2:0]               dbg_state
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] SETTLE  = 3'd2;
   localparam logic [2:0] WAIT    = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;
   localparam logic [2:0] RECOVER = 3'd5;

   logic [2:0]              state;
   logic [2:0]              ptr;
   logic [2:0]              winner;
   logic                    found;
   logic [7:0]              elig8;
   logic [7:0]              rw8;
   logic [7:0]              sub_arr [8];
   logic [7:0]              wr_arr  [8];
   logic [NUM_CLIENTS-1:0]  ack_next;
   logic [TIMEOUT_BITS-1:0] wdog;
   logic [3:0]              rcnt;
   logic                    err;
   logic [7:0]              rdata;

   // cl_ack is a register, so a client still holding req during its ack cycle is not re-granted.
   assign elig8     = 8'(cl_req & ~cl_ack);
   assign rw8       = 8'(cl_rw);
   assign dbg_state = state;

   for (genvar g = 0; g < 8; g++) begin : g_unpack
      if (g < NUM_CLIENTS) begin : g_used
         assign sub_arr[g] = cl_subaddr[8*g +: 8];
         assign wr_arr[g]  = cl_wrdata[8*g +: 8];
      end else begin : g_unused
         assign sub_arr[g] = 8'h00;
         assign wr_arr[g]  = 8'h00;
      end
   end

   // Search upward from the client after the last winner, wrapping at NUM_CLIENTS.
   always_comb begin
      logic [3:0] k;
      k      = 4'd0;
      winner = ptr;
      found  = 1'b0;
      for (int i = 1; i <= NUM_CLIENTS; i++) begin
         k = {1'b0, ptr} + 4'(i);
         if (k >= 4'(NUM_CLIENTS)) k = k - 4'(NUM_CLIENTS);
         if (!found && elig8[k[2:0]]) begin
            found  = 1'b1;
            winner = k[2:0];
         end
      end
   end

   always_comb begin
      ack_next = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         ack_next[i] = (grant_id == 3'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 3'(NUM_CLIENTS - 1);
         grant_id  <= 3'd0;
         m_rw      <= 1'b0;
         m_subaddr <= 8'h00;
         m_wrdata  <= 8'h00;
         m_req     <= 1'b0;
         m_rst     <= 1'b0;
         cl_ack    <= '0;
         cl_err    <= 1'b0;
         cl_rddata <= 8'h00;
         wdog      <= '0;
         rcnt      <= 4'd0;
         err       <= 1'b0;
         rdata     <= 8'h00;
      end else begin
         cl_ack <= '0;
         cl_err <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  m_rw      <= rw8[winner];
                  m_subaddr <= sub_arr[winner];
                  m_wrdata  <= wr_arr[winner];
                  grant_id  <= winner;
                  ptr       <= winner;
                  m_req     <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               m_req <= 1'b0;
               wdog  <= '0;
               state <= SETTLE;
            end
            SETTLE: state <= WAIT;
            WAIT: begin
               wdog <= wdog + 1'b1;
               if (m_nack || (&wdog)) begin
                  err   <= 1'b1;
                  rdata <= 8'h00;
                  m_rst <= 1'b1;
                  rcnt  <= 4'(RST_CYCLES - 1);
                  state <= RECOVER;
               end else if (!m_busy) begin
                  err   <= 1'b0;
                  rdata <= m_rw ? m_rddata : 8'h00;
                  state <= DONE;
               end
            end
            RECOVER: begin
               if (rcnt == 4'd0) begin
                  m_rst <= 1'b0;
                  state <= DONE;
               end else begin
                  rcnt <= rcnt - 4'd1;
               end
            end
            DONE: begin
               cl_ack    <= ack_next;
               cl_err    <= err;
               cl_rddata <= rdata;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
